branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the pipelined core. It sits in the fetch stage and gives the next-PC mux a predicted direction and target for the current fetch PC. It is trained in execute by the branch comparator's resolved outcome and raises a mispredict/redirect when the fetch-time prediction was wrong. Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.

## Interface
- ENTRIES, 16, number of table entries; power of two, 4..256; IDX_W = log2(ENTRIES)
- clk  in  1  rising-edge clock; only clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  fetch-stage PC (word aligned)
- pred_taken  out  1  prediction for if_pc
- pred_target  out  32  predicted next PC for if_pc
- ex_valid  in  1  a conditional branch is resolved in execute this cycle
- ex_pc  in  32  PC of the resolved branch
- ex_taken  in  1  comparator outcome (bit 0 of comparator output)
- ex_target  in  32  computed branch target
- ex_pred_taken  in  1  pred_taken piped down with this branch
- ex_pred_target  in  32  pred_target piped down with this branch
- mispredict  out  1  flush fetch/decode and redirect
- redirect_pc  out  32  correct next PC for the resolved branch
- br_count  out  32  resolved branches since reset
- miss_count  out  32  mispredicts since reset

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[31:IDX_W+2]. Hit means the entry is valid and its tag equals the tag of the PC being looked up.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Prediction is combinational from the table:
  - On a hit with counter[1]=1: pred_taken=1 and pred_target=entry target.
  - Otherwise: pred_taken=0 and pred_target=if_pc+4, with 32-bit wrap.
- mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)). It is combinational.
- redirect_pc = ex_taken ? ex_target : ex_pc+4. The output is driven every cycle and is meaningful only when mispredict=1.
- Update happens on the clock edge when ex_valid=1, using ex_pc's index and tag:
  - Hit, taken: counter increments, saturating at 11; target is written with ex_target.
  - Hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Miss, taken: the entry is allocated and overwrites any occupant. Fields: valid=1, tag, target=ex_target, counter=10.
  - Miss, not taken: no change to the table.
- Statistics update on the same edge when ex_valid=1:
  - br_count increments.
  - miss_count increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
- When ex_valid=0, neither the table nor the counters change, whatever the other ex_* inputs are.

## Timing
- Prediction latency: 0 cycles (combinational read of registered state).
- Training latency: 1 cycle. An update becomes visible to lookups from the cycle after the edge.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents; there is no write-through bypass.
- Reset takes effect on the rising edge with rst=1 and has priority over any update on that edge:
  - Every entry: valid=0, counter=01, tag=0, target=0.
  - br_count=0 and miss_count=0.
  - With every entry invalid, pred_taken=0 and pred_target=if_pc+4.
- Reset asserted mid-stream discards the pending update on that edge. Counting restarts from 0 on the first ex_valid edge after rst deasserts.
- The table is implemented in registers, not a synchronous-read RAM.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104, br_count=0, miss_count=0.
- Cold taken branch: ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x40, ex_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x40.
  - Next cycle with if_pc=0x100: pred_taken=1, pred_target=0x40.
  - miss_count=1.
- Saturation: train 0x100 taken ×3 (counter reaches 11), then not-taken ×1 → still predicts taken. A second not-taken → predicts not taken and pred_target=0x104.
- Aliasing with ENTRIES=16: 0x100 is allocated taken. A taken branch at 0x140 (same index, different tag) evicts it → if_pc=0x100 now misses and gives pred_taken=0.
- Target change: with 0x100 in state 11, resolve taken to 0x80 while ex_pred_target=0x40 → mispredict=1, redirect_pc=0x80, new target 0x80. Not-taken miss at 0x200 → no allocation, mispredict=0 when ex_pred_taken=0.
- Same-edge read/write at 0x100: the lookup shows the old prediction and the following cycle shows the new one. rst asserted during a valid update → table and counts cleared, update dropped.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direct-mapped table of valid/tag/target/2-bit
// counter entries. It is read combinationally in fetch and trained on the
// resolved outcome of a conditional branch in execute.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [31:0] br_count_q, br_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  // PCs are word aligned, so the low two bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Fetch-side prediction reads registered state only, so a same-cycle update
  // is not visible until the following cycle.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if (if_hit && ctr_q[if_idx][1]) begin
      pred_taken  = 1'b1;
      pred_target = target_q[if_idx];
    end
  end

  // Resolution check: wrong direction, or right direction to the wrong target.
  always_comb begin
    mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
  end

  // Table training: hits move the counter, taken misses allocate over any occupant.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (ex_valid) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = ex_target;
        end else begin
          if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  // Saturating statistics counters for resolved branches and mispredicts.
  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (ex_valid) begin
      if (br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
      if (mispredict && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
    end
  end

  // State registers; reset wins over any update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule
